gcm_block_sequencer: RTL

//  Upstream front end of gcm_aes. Accepts one GCM job: a header (key, IV, AAD and PT bit lengths)

---
 rtl/gcm_pkg.sv | 31 +++
 rtl/gcm_len_counter.sv | 33 +++
 rtl/gcm_block_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/gcm_pkg.sv
// Shared widths, enums and the final-block mask helper for the GCM front end.
// Bit 0 of a block is its MSB, so "bits [r:127]" are the low-order value bits.
package gcm_pkg;
    localparam int AES_BLK_W = 128;
    localparam int IV_W      = 96;
    localparam int LEN_W     = 64;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_FRAMING = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_AAD      = 3'd2,
        ST_PT       = 3'd3,
        ST_WAIT_TAG = 3'd4
    } state_e;

    // Keeps the first (len % 128) MSB-first bits of the final block; a full block passes through.
    function automatic logic [AES_BLK_W-1:0] blk_mask(input logic [LEN_W-1:0] len);
        logic [6:0] r;
        r = 7'(len % LEN_W'(AES_BLK_W));
        if (r == 7'd0)
            blk_mask = '1;
        else
            blk_mask = ~({AES_BLK_W{1'b1}} >> r);
    endfunction
endpackage

// File: rtl/gcm_len_counter.sv
// Turns a bit length into a block count, counts it down per accepted beat and
// provides the mask for whichever block is currently the last one.
module gcm_len_counter
    import gcm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [LEN_W-1:0]     len,
    input  logic                 dec,
    output logic                 empty,
    output logic                 is_last,
    output logic [AES_BLK_W-1:0] mask
);
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            len_q <= '0;
        end else if (load) begin
            count <= (len >> 7) + LEN_W'(len[6:0] != 7'd0);
            len_q <= len;
        end else if (dec && (count != '0)) begin
            count <= count - LEN_W'(1);
        end
    end

    assign empty   = (count == '0);
    assign is_last = (count == LEN_W'(1));
    assign mask    = is_last ? blk_mask(len_q) : '1;
endmodule

// File: rtl/gcm_block_sequencer.sv
// Front end of gcm_aes: takes one header plus AAD/PT block stream per job, drives the
// core's new_instance/pt_instance protocol, masks partial blocks and reports tag/error.
module gcm_block_sequencer
    import gcm_pkg::*;
#(
    parameter int SETUP_CYCLES = 5,
    parameter int TAG_TIMEOUT  = 64
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_hdr_valid,
    output logic                 o_hdr_ready,
    input  logic [AES_BLK_W-1:0] i_cipher_key,
    input  logic [IV_W-1:0]      i_iv,
    input  logic [LEN_W-1:0]     i_aad_bits,
    input  logic [LEN_W-1:0]     i_pt_bits,
    input  logic                 i_blk_valid,
    output logic                 o_blk_ready,
    input  logic [AES_BLK_W-1:0] i_blk_data,
    input  logic                 i_blk_last,
    output logic                 o_new_instance,
    output logic                 o_pt_instance,
    output logic [AES_BLK_W-1:0] o_cipher_key,
    output logic [IV_W-1:0]      o_iv,
    output logic [AES_BLK_W-1:0] o_aad,
    output logic [AES_BLK_W-1:0] o_plain_text,
    output logic [LEN_W-1:0]     o_aad_size,
    output logic [LEN_W-1:0]     o_pt_size,
    input  logic                 i_tag_ready,
    input  logic [AES_BLK_W-1:0] i_tag,
    output logic                 o_done,
    output logic [AES_BLK_W-1:0] o_tag,
    output logic [1:0]           o_err
);
    localparam int CNT_W = 16;

    state_e               state;
    logic [CNT_W-1:0]     setup_cnt;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 framing_err;
    logic                 pt_first;
    logic                 hdr_take;
    logic                 beat;
    logic                 aad_empty, aad_is_last, pt_empty, pt_is_last;
    logic [AES_BLK_W-1:0] aad_mask, pt_mask;

    assign o_hdr_ready = (state == ST_IDLE);
    assign hdr_take    = i_hdr_valid && o_hdr_ready;
    assign beat        = i_blk_valid && o_blk_ready;

    // Block 0 is accepted only before new_instance rises; the SETUP hold window takes no beats.
    always_comb begin
        o_blk_ready = 1'b0;
        case (state)
            ST_SETUP: o_blk_ready = !aad_empty && !o_new_instance;
            ST_AAD:   o_blk_ready = 1'b1;
            ST_PT:    o_blk_ready = !pt_empty;
            default:  o_blk_ready = 1'b0;
        endcase
    end

    gcm_len_counter u_aad_cnt (
        .clk     (clk),
        .rst_n   (i_rst_n),
        .load    (hdr_take),
        .len     (i_aad_bits),
        .dec     (beat && ((state == ST_SETUP) || (state == ST_AAD))),
        .empty   (aad_empty),
        .is_last (aad_is_last),
        .mask    (aad_mask)
    );

    gcm_len_counter u_pt_cnt (
        .clk     (clk),
        .rst_n   (i_rst_n),
        .load    (hdr_take),
        .len     (i_pt_bits),
        .dec     (beat && (state == ST_PT)),
        .empty   (pt_empty),
        .is_last (pt_is_last),
        .mask    (pt_mask)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            setup_cnt      <= '0;
            wait_cnt       <= '0;
            framing_err    <= 1'b0;
            pt_first       <= 1'b0;
            o_new_instance <= 1'b0;
            o_pt_instance  <= 1'b0;
            o_cipher_key   <= '0;
            o_iv           <= '0;
            o_aad          <= '0;
            o_plain_text   <= '0;
            o_aad_size     <= '0;
            o_pt_size      <= '0;
            o_done         <= 1'b0;
            o_tag          <= '0;
            o_err          <= ERR_OK;
        end else begin
            o_done        <= 1'b0;
            o_pt_instance <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hdr_take) begin
                        o_cipher_key <= i_cipher_key;
                        o_iv         <= i_iv;
                        o_aad_size   <= i_aad_bits;
                        o_pt_size    <= i_pt_bits;
                        framing_err  <= 1'b0;
                        pt_first     <= 1'b1;
                        state        <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (!o_new_instance) begin
                        if (aad_empty || beat) begin
                            o_aad          <= aad_empty ? '0 : (i_blk_data & aad_mask);
                            o_new_instance <= 1'b1;
                            setup_cnt      <= CNT_W'(1);
                            if (beat && i_blk_last)
                                framing_err <= 1'b1;
                        end
                    end else if (setup_cnt == CNT_W'(SETUP_CYCLES)) begin
                        o_new_instance <= 1'b0;
                        state          <= aad_empty ? ST_PT : ST_AAD;
                    end else begin
                        setup_cnt <= setup_cnt + CNT_W'(1);
                    end
                end
                ST_AAD: begin
                    if (beat) begin
                        o_aad <= i_blk_data & aad_mask;
                        if (i_blk_last)
                            framing_err <= 1'b1;
                        if (aad_is_last)
                            state <= ST_PT;
                    end
                end
                ST_PT: begin
                    // An empty PT stream still needs one zero block to kick the core's PT phase.
                    if (pt_empty) begin
                        o_plain_text  <= '0;
                        o_pt_instance <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= ST_WAIT_TAG;
                    end else if (beat) begin
                        o_plain_text  <= i_blk_data & pt_mask;
                        o_pt_instance <= pt_first;
                        pt_first      <= 1'b0;
                        if (i_blk_last != pt_is_last)
                            framing_err <= 1'b1;
                        if (pt_is_last) begin
                            wait_cnt <= '0;
                            state    <= ST_WAIT_TAG;
                        end
                    end
                end
                ST_WAIT_TAG: begin
                    if (i_tag_ready) begin
                        o_tag  <= i_tag;
                        o_done <= 1'b1;
                        o_err  <= framing_err ? ERR_FRAMING : ERR_OK;
                        state  <= ST_IDLE;
                    end else if (wait_cnt == CNT_W'(TAG_TIMEOUT - 1)) begin
                        o_done <= 1'b1;
                        o_err  <= ERR_TIMEOUT;
                        state  <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
